// File: rtl/dp_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// dp_ctrl_fsm
//   Multi-cycle control unit for the ARM data-processing CPU datapath.
//   Sequences FETCH / DECODE / EXEC / WB. It decodes data-processing
//   instructions held in IR into ALU, shifter and operand selects, and
//   checks the condition field against NZCV. Execution is gated by the
//   board run/step switches.
//
// Parameters
//   CNT_W     width of the retired-instruction counter (wraps)
//   COND_EN   1: evaluate IR[31:28]; 0: every cond is AL (1111 still NOP)
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   run                   level: execute instructions back to back
//   step                  one-clock pulse: execute one instruction from IDLE
//   IR, NZCV              instruction register, current flags {N,Z,C,V}
//   Write_PC, Write_IR    fetch strobes
//   Write_Reg             register-file write strobe (Rd)
//   LA, LB, LC            latch the Rn / Rm / Rs operands
//   LF                    latch the ALU result
//   S                     flag-update strobe
//   rm_imm_s              B operand select (0 Rm, 1 imm8)
//   rs_imm_s              shift amount select (00 Rs, 01 IR[11:7], 10 rot*2)
//   ALU_OP, SHIFT_OP      registered ALU / shifter operation fields
//   state, busy           current state, state != IDLE
//   retired               count of executed instructions
// ---------------------------------------------------------------------------
module dp_ctrl_fsm #(
   parameter int unsigned CNT_W   = 16,
   parameter bit          COND_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             step,
   input  logic [31:0]      IR,
   input  logic [3:0]       NZCV,
   output logic             Write_PC,
   output logic             Write_IR,
   output logic             Write_Reg,
   output logic             LA,
   output logic             LB,
   output logic             LC,
   output logic             LF,
   output logic             S,
   output logic             rm_imm_s,
   output logic [1:0]       rs_imm_s,
   output logic [3:0]       ALU_OP,
   output logic [2:0]       SHIFT_OP,
   output logic [2:0]       state,
   output logic             busy,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4
   } state_t;

   state_t st;
   logic   s_lat;       // flag update for the instruction in flight
   logic   cond_pass;
   logic   non_dp;
   logic   is_cmp_ir;   // opcode 10xx, decoded straight from IR
   logic   is_cmp_reg;  // same, from the latched ALU_OP (valid after DECODE)

   // Bits of IR that this unit never looks at.
   logic   unused_ir;
   assign unused_ir = ^{IR[19:8], IR[3:0]};

   logic n_f, z_f, c_f, v_f;
   assign {n_f, z_f, c_f, v_f} = NZCV;

   // Condition evaluation
   always_comb begin
      cond_pass = 1'b0;
      if (COND_EN) begin
         unique case (IR[31:28])
            4'h0: cond_pass = z_f;
            4'h1: cond_pass = !z_f;
            4'h2: cond_pass = c_f;
            4'h3: cond_pass = !c_f;
            4'h4: cond_pass = n_f;
            4'h5: cond_pass = !n_f;
            4'h6: cond_pass = v_f;
            4'h7: cond_pass = !v_f;
            4'h8: cond_pass = c_f && !z_f;
            4'h9: cond_pass = !c_f || z_f;
            4'hA: cond_pass = (n_f == v_f);
            4'hB: cond_pass = (n_f != v_f);
            4'hC: cond_pass = !z_f && (n_f == v_f);
            4'hD: cond_pass = z_f || (n_f != v_f);
            4'hE: cond_pass = 1'b1;
            4'hF: cond_pass = 1'b0;
            default: cond_pass = 1'b0;
         endcase
      end else begin
         cond_pass = (IR[31:28] != 4'hF);
      end
   end

   assign is_cmp_ir  = (IR[24:23] == 2'b10);
   assign is_cmp_reg = (ALU_OP[3:2] == 2'b10);

   // Not a data-processing instruction: other class, multiply/extra
   // load-store space, or a compare without S (MRS/MSR/misc space).
   assign non_dp = (IR[27:26] != 2'b00)
                || (!IR[25] && IR[7] && IR[4])
                || (is_cmp_ir && !IR[20]);

   // Sequencer, field registers and retired counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= ST_IDLE;
         s_lat    <= 1'b0;
         rm_imm_s <= 1'b0;
         rs_imm_s <= '0;
         ALU_OP   <= '0;
         SHIFT_OP <= '0;
         retired  <= '0;
      end else begin
         unique case (st)
            ST_IDLE: begin
               if (run || step)
                  st <= ST_FETCH;
            end
            ST_FETCH: begin
               st <= ST_DECODE;
            end
            ST_DECODE: begin
               ALU_OP <= IR[24:21];
               s_lat  <= IR[20] || is_cmp_ir;
               if (IR[25]) begin
                  rm_imm_s <= 1'b1;
                  rs_imm_s <= 2'b10;
                  SHIFT_OP <= 3'b110;
               end else if (!IR[4]) begin
                  rm_imm_s <= 1'b0;
                  rs_imm_s <= 2'b01;
                  SHIFT_OP <= {IR[6:5], 1'b0};
               end else begin
                  rm_imm_s <= 1'b0;
                  rs_imm_s <= 2'b00;
                  SHIFT_OP <= {IR[6:5], 1'b1};
               end
               if (non_dp || !cond_pass)
                  st <= run ? ST_FETCH : ST_IDLE;
               else
                  st <= ST_EXEC;
            end
            ST_EXEC: begin
               if (is_cmp_reg) begin
                  retired <= retired + 1'b1;
                  st      <= run ? ST_FETCH : ST_IDLE;
               end else begin
                  st <= ST_WB;
               end
            end
            ST_WB: begin
               retired <= retired + 1'b1;
               st      <= run ? ST_FETCH : ST_IDLE;
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

   // Moore strobes decoded from the state register, so an async reset
   // clears them in the same cycle.
   always_comb begin
      Write_PC  = 1'b0;
      Write_IR  = 1'b0;
      Write_Reg = 1'b0;
      LA        = 1'b0;
      LB        = 1'b0;
      LC        = 1'b0;
      LF        = 1'b0;
      S         = 1'b0;
      unique case (st)
         ST_FETCH: begin
            Write_PC = 1'b1;
            Write_IR = 1'b1;
         end
         ST_DECODE: begin
            LA = 1'b1;
            LB = 1'b1;
            LC = 1'b1;
         end
         ST_EXEC: begin
            LF = 1'b1;
            S  = s_lat;
         end
         ST_WB: begin
            Write_Reg = 1'b1;
         end
         default: ;
      endcase
   end

   assign state = st;
   assign busy  = (st != ST_IDLE);

endmodule
